// File: rtl/bidir_pin_bank_pkg.sv
// Shared types and constants for the bidirectional pin bank.
package bidir_pin_bank_pkg;

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_IN  = 2'd3
    } state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned TURN_CYCLES_MIN = 1;
    localparam int unsigned TURN_CYCLES_MAX = 15;

    localparam int unsigned TURN_CNT_W      = 4;
    localparam int unsigned SETTLE_CNT_W    = 3;
    localparam int unsigned RST_SYNC_STAGES = 2;

endpackage

// File: rtl/bidir_pin_bank_pin_sync.sv
// Multi-flop input synchroniser for the pad bus; exposes the last stage and the one before it.
module pin_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_pre
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q     = r_stage[SYNC_STAGES-1];
    assign o_q_pre = r_stage[SYNC_STAGES-2];

endmodule

// File: rtl/bidir_pin_bank.sv
// Bidirectional pad bank: direction FSM with high-Z turnaround, registered drive path,
// synchronised receive path with settle tracking and change detection.
module bidir_pin_bank
    import bidir_pin_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] data_out,
    inout  wire  [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] data_in,
    output logic             in_valid,
    output logic             in_change,
    output logic             oe,
    output logic             busy
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
        $error("bidir_pin_bank: SYNC_STAGES out of range");
    end
    if (TURN_CYCLES < TURN_CYCLES_MIN || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_turn_cycles
        $error("bidir_pin_bank: TURN_CYCLES out of range");
    end

    localparam logic [TURN_CNT_W-1:0]   TURN_LOAD   = TURN_CNT_W'(TURN_CYCLES - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SYNC_STAGES - 1);

    logic [RST_SYNC_STAGES-1:0] r_rst_sync;
    logic                       w_rel;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [TURN_CNT_W-1:0]   r_turn_cnt;
    logic [TURN_CNT_W-1:0]   w_turn_cnt_nxt;
    logic [SETTLE_CNT_W-1:0] r_settle_cnt;
    logic [SETTLE_CNT_W-1:0] w_settle_cnt_nxt;

    logic             r_oe;
    logic             r_busy;
    logic             r_in_valid;
    logic             r_in_change;
    logic [WIDTH-1:0] r_out_q;

    logic             w_settle_done;
    logic             w_in_valid_nxt;
    logic             w_in_change_nxt;
    logic             w_busy_nxt;
    logic             w_oe_nxt;
    logic             w_out_load;
    logic [WIDTH-1:0] w_sync_pre;

    // Reset deassertion is synchronised; assertion still clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rel = r_rst_sync[RST_SYNC_STAGES-1];

    pin_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (pin),
        .o_q     (data_in),
        .o_q_pre (w_sync_pre)
    );

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IN;
            r_turn_cnt   <= '0;
            r_settle_cnt <= '0;
            r_oe         <= 1'b0;
            r_busy       <= 1'b1;
            r_in_valid   <= 1'b0;
            r_in_change  <= 1'b0;
            r_out_q      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_turn_cnt   <= w_turn_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_oe         <= w_oe_nxt;
            r_busy       <= w_busy_nxt;
            r_in_valid   <= w_in_valid_nxt;
            r_in_change  <= w_in_change_nxt;
            if (w_out_load) begin
                r_out_q <= data_out;
            end
        end
    end

    // Next-state and turnaround counter; dir_req is not looked at inside a turnaround.
    always_comb begin
        w_state_nxt    = r_state;
        w_turn_cnt_nxt = r_turn_cnt;
        case (r_state)
            ST_IN: begin
                if (w_rel && dir_req) begin
                    w_state_nxt    = ST_TURN_OUT;
                    w_turn_cnt_nxt = TURN_LOAD;
                end
            end
            ST_TURN_OUT: begin
                if (r_turn_cnt == '0) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt - TURN_CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (!dir_req) begin
                    w_state_nxt    = ST_TURN_IN;
                    w_turn_cnt_nxt = TURN_LOAD;
                end
            end
            ST_TURN_IN: begin
                if (r_turn_cnt == '0) begin
                    w_state_nxt = ST_IN;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt - TURN_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IN;
            end
        endcase
    end

    // Output next-values, settle tracking and drive-register load enable.
    always_comb begin
        w_settle_cnt_nxt = r_settle_cnt;
        w_settle_done    = (r_state == ST_IN) && w_rel && !r_in_valid
                           && (r_settle_cnt == SETTLE_LAST);
        if ((w_state_nxt == ST_IN) && (r_state != ST_IN)) begin
            w_settle_cnt_nxt = '0;
        end else if ((r_state == ST_IN) && w_rel && !r_in_valid && !w_settle_done) begin
            w_settle_cnt_nxt = r_settle_cnt + SETTLE_CNT_W'(1);
        end

        w_in_valid_nxt  = (w_state_nxt == ST_IN) && (r_in_valid || w_settle_done);
        w_in_change_nxt = w_in_valid_nxt && r_in_valid && (w_sync_pre != data_in);
        w_oe_nxt        = (w_state_nxt == ST_OUT);
        w_busy_nxt      = (w_state_nxt == ST_TURN_OUT) || (w_state_nxt == ST_TURN_IN)
                          || ((w_state_nxt == ST_IN) && !w_in_valid_nxt);
        w_out_load      = (r_state == ST_TURN_OUT) || (r_state == ST_OUT);
    end

    assign pin       = r_oe ? r_out_q : {WIDTH{1'bz}};
    assign oe        = r_oe;
    assign busy      = r_busy;
    assign in_valid  = r_in_valid;
    assign in_change = r_in_change;

endmodule
